// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write architectural register file.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] reg_word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: index mux, x0 masking, optional write-through bypass.
// REGFILE_BYPASS_EN forwards same-cycle write data to a matching nonzero read.
module regfile_read_port
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_word_t mem [NREG],
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_word_t wdata,
  input  logic      re,
  input  reg_addr_t raddr,
  output reg_word_t rdata,
  output logic      rvalid
);

  reg_word_t value;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    value = mem[raddr];
    if (raddr == REG_ZERO) begin
      value = '0;
    end else if (we && (waddr == raddr)) begin
      value = wdata;
    end
  end
`else
  // Write port is only consumed by the bypass build.
  logic unused_wr;
  assign unused_wr = ^{we, waddr, wdata};

  always_comb begin
    value = mem[raddr];
    if (raddr == REG_ZERO) begin
      value = '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= value;
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two registered read ports and one write port; x0 reads zero.
// REGFILE_BYPASS_EN enables write-through forwarding on same-cycle write/read.
module regfile_2r1w
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_word_t wdata,
  input  logic      re_a,
  input  reg_addr_t raddr_a,
  output reg_word_t rdata_a,
  output logic      rvalid_a,
  input  logic      re_b,
  input  reg_addr_t raddr_b,
  output reg_word_t rdata_b,
  output logic      rvalid_b
);

  reg_word_t mem [NREG];

  // Writes to x0 are dropped, so mem[0] stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      mem[waddr] <= wdata;
    end
  end

  regfile_read_port u_port_a (
    .clk    (clk),
    .rst    (rst),
    .mem    (mem),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re_a),
    .raddr  (raddr_a),
    .rdata  (rdata_a),
    .rvalid (rvalid_a)
  );

  regfile_read_port u_port_b (
    .clk    (clk),
    .rst    (rst),
    .mem    (mem),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re_b),
    .raddr  (raddr_b),
    .rdata  (rdata_b),
    .rvalid (rvalid_b)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: driver queues expected read data, monitor checks on rvalid.
module tb_regfile_2r1w;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      we;
  reg_addr_t waddr;
  reg_word_t wdata;
  logic      re_a;
  reg_addr_t raddr_a;
  reg_word_t rdata_a;
  logic      rvalid_a;
  logic      re_b;
  reg_addr_t raddr_b;
  reg_word_t rdata_b;
  logic      rvalid_b;

  int errors = 0;
  int checks = 0;

  reg_word_t qa[$];
  reg_word_t qb[$];

  regfile_2r1w dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re_a     (re_a),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .rvalid_a (rvalid_a),
    .re_b     (re_b),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .rvalid_b (rvalid_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one cycle of stimulus at the falling edge; expected read data goes to the scoreboard.
  task automatic step(input logic w, input reg_addr_t wa, input reg_word_t wd,
                      input logic ea, input reg_addr_t ra, input reg_word_t xa,
                      input logic eb, input reg_addr_t rb, input reg_word_t xb);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd;
    re_a = ea; raddr_a = ra;
    re_b = eb; raddr_b = rb;
    if (ea) qa.push_back(xa);
    if (eb) qb.push_back(xb);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic wr(input reg_addr_t a, input reg_word_t d);
    step(1'b1, a, d, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Monitor: compares every presented read result against the queued expectation.
  always @(negedge clk) begin
    if (rvalid_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL port_a_unexpected: got 0x%08h expected no valid", rdata_a);
      end else begin
        check("port_a_data", rdata_a, qa.pop_front());
      end
    end
    if (rvalid_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL port_b_unexpected: got 0x%08h expected no valid", rdata_b);
      end else begin
        check("port_b_data", rdata_b, qb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
    #1;
    check("reset_rdata_a", rdata_a, 32'h0);
    check("reset_rdata_b", rdata_b, 32'h0);
    check("reset_rvalid", {30'h0, rvalid_a, rvalid_b}, 32'h0);
    #11 rst = 1'b0;

    // Reset mid-operation
    wr(5'd5, 32'h12345678);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h12345678, 1'b1, 5'd5, 32'h12345678);
    idle();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rdata_a", rdata_a, 32'h0);
    check("async_rst_rdata_b", rdata_b, 32'h0);
    check("async_rst_rvalid", {30'h0, rvalid_a, rvalid_b}, 32'h0);
    #1 rst = 1'b0;
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0);

    // Basic read/write and hold
    wr(5'd7, 32'hDEADBEEF);
    wr(5'd31, 32'h0000CAFE);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 5'd31, 32'h0000CAFE);
    idle();
    @(posedge clk); #1;
    check("hold_rdata_a", rdata_a, 32'hDEADBEEF);
    check("hold_rdata_b", rdata_b, 32'h0000CAFE);
    check("hold_rvalid", {30'h0, rvalid_a, rvalid_b}, 32'h0);

    // x0 hardwiring, including a same-cycle write to x0
    wr(5'd0, 32'hFFFFFFFF);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Same-cycle write/read hazard on x3
    wr(5'd3, 32'h11111111);
`ifdef REGFILE_BYPASS_EN
    step(1'b1, 5'd3, 32'h22222222, 1'b1, 5'd3, 32'h22222222, 1'b0, 5'd0, 32'h0);
`else
    step(1'b1, 5'd3, 32'h22222222, 1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 32'h0);
`endif
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h22222222, 1'b1, 5'd3, 32'h22222222);

    // Dual-port same index, then port B holds while A reads x10
    wr(5'd9, 32'hA5A5A5A5);
    wr(5'd10, 32'h5A5A5A5A);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 32'hA5A5A5A5);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h5A5A5A5A, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    check("dual_hold_rdata_b", rdata_b, 32'hA5A5A5A5);
    check("dual_hold_rvalid_b", {31'h0, rvalid_b}, 32'h0);
    idle();

    // Drain: bounded wait for the scoreboard to empty
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
